// File: rtl/fd_pkg.sv
// fd_pkg: shared definitions for the RV32I fetch/decode front end.
//  - RV32I major opcode constants used by the decoder
//  - imm_fmt_e: immediate encoding selected by the decoder
//  - sext12: helper that sign-extends a 12-bit immediate field
package fd_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  function automatic logic [31:0] sext12(input logic [11:0] val);
    return {{20{val[11]}}, val};
  endfunction

endpackage

// File: rtl/fetch_decode_unit_reg_file.sv
// reg_file: 32 x 32-bit integer register file.
// Ports:
//   clk_i            clock, writes on rising edge
//   rst_i            asynchronous active-high reset, clears every register
//   we_i             write enable
//   waddr_i/wdata_i  write port (writes to address 0 are dropped)
//   raddr1_i/2_i     asynchronous read addresses
//   rdata1_o/2_o     read data; address 0 always reads zero
// Reads return the registered contents only, so a read of the register being
// written in the same cycle sees the old value.
module reg_file (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);

  logic [31:0] regs_q [32];

  // x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : regs_q[raddr2_i];

endmodule

// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit: front end of a single-cycle RV32I core.
// Holds the PC, decodes the instruction word returned by the external
// combinational instruction memory, and owns the register file.
// Ports:
//   clk_i        clock
//   reset_i      asynchronous active-high reset (PC and register file)
//   pc_update_i  load pc_new_i at the next edge instead of stepping
//   pc_new_i     branch/jump target (low two bits ignored)
//   pc_o         current PC
//   komut_i      instruction word fetched at pc_o
//   opcode_o     komut[6:0]
//   func_o       {funct7[5], funct3}
//   rs1_data_o   register file read of rs1
//   rs2_data_o   register file read of rs2
//   imm_o        sign-extended immediate for the decoded format
//   hata_o       illegal/unsupported instruction
//   we_o         instruction writes rd this cycle
//   rd_data_i    write-back value for rd
module fetch_decode_unit
  import fd_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        pc_update_i,
  input  logic [31:0] pc_new_i,
  output logic [31:0] pc_o,
  input  logic [31:0] komut_i,
  output logic [6:0]  opcode_o,
  output logic [3:0]  func_o,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  output logic [31:0] imm_o,
  output logic        hata_o,
  output logic        we_o,
  input  logic [31:0] rd_data_i
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  imm_fmt_e    immFmt;
  logic        illegal;
  logic        writesRd;

  assign opcode = komut_i[6:0];
  assign funct3 = komut_i[14:12];
  assign funct7 = komut_i[31:25];

  // Jump targets are forced word aligned; the step adder wraps naturally.
  assign pc_d = pc_update_i ? (pc_new_i & 32'hFFFF_FFFC) : (pc_q + PC_STEP);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

  // Classify the opcode: immediate format, whether it writes rd, and the
  // funct3/funct7 combinations that are not part of RV32I.
  always_comb begin
    immFmt   = FMT_R;
    illegal  = 1'b0;
    writesRd = 1'b0;
    case (opcode)
      OP_R: begin
        writesRd = 1'b1;
        // funct7 0x20 only encodes sub (000) and sra (101).
        if (!((funct7 == 7'h00) ||
              ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))))) begin
          illegal = 1'b1;
        end
      end
      OP_IMM: begin
        immFmt   = FMT_I;
        writesRd = 1'b1;
        // Shift-immediates reuse imm[11:5] as funct7.
        if ((funct3 == 3'b001) && (funct7 != 7'h00)) begin
          illegal = 1'b1;
        end
        if ((funct3 == 3'b101) && (funct7 != 7'h00) && (funct7 != 7'h20)) begin
          illegal = 1'b1;
        end
      end
      OP_LOAD: begin
        immFmt   = FMT_I;
        writesRd = 1'b1;
        if ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111)) begin
          illegal = 1'b1;
        end
      end
      OP_STORE: begin
        immFmt = FMT_S;
        if (funct3 > 3'b010) begin
          illegal = 1'b1;
        end
      end
      OP_BRANCH: begin
        immFmt = FMT_B;
        if ((funct3 == 3'b010) || (funct3 == 3'b011)) begin
          illegal = 1'b1;
        end
      end
      OP_JAL: begin
        immFmt   = FMT_J;
        writesRd = 1'b1;
      end
      OP_JALR: begin
        immFmt   = FMT_I;
        writesRd = 1'b1;
        if (funct3 != 3'b000) begin
          illegal = 1'b1;
        end
      end
      OP_LUI, OP_AUIPC: begin
        immFmt   = FMT_U;
        writesRd = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // Immediate assembly; unknown opcodes keep FMT_R and therefore read zero.
  always_comb begin
    imm_o = 32'd0;
    case (immFmt)
      FMT_I: imm_o = sext12(komut_i[31:20]);
      FMT_S: imm_o = sext12({komut_i[31:25], komut_i[11:7]});
      FMT_B: imm_o = {{19{komut_i[31]}}, komut_i[31], komut_i[7],
                      komut_i[30:25], komut_i[11:8], 1'b0};
      FMT_U: imm_o = {komut_i[31:12], 12'h000};
      FMT_J: imm_o = {{11{komut_i[31]}}, komut_i[31], komut_i[19:12],
                      komut_i[20], komut_i[30:21], 1'b0};
      default: imm_o = 32'd0;
    endcase
  end

  assign opcode_o = opcode;
  assign func_o   = {komut_i[30], funct3};
  assign hata_o   = illegal;
  assign we_o     = writesRd & ~illegal;

  reg_file u_reg_file (
    .clk_i    (clk_i),
    .rst_i    (reset_i),
    .we_i     (we_o),
    .waddr_i  (komut_i[11:7]),
    .wdata_i  (rd_data_i),
    .raddr1_i (komut_i[19:15]),
    .raddr2_i (komut_i[24:20]),
    .rdata1_o (rs1_data_o),
    .rdata2_o (rs2_data_o)
  );

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Testbench for fetch_decode_unit: PC sequencing, decode table and register
// file sequences, with expected results queued when stimulus is driven.
module tb_fetch_decode_unit;

  logic        clk;
  logic        reset;
  logic        pcUpdate;
  logic [31:0] pcNew;
  logic [31:0] pc;
  logic [31:0] komut;
  logic [6:0]  opcode;
  logic [3:0]  func;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic [31:0] imm;
  logic        hata;
  logic        we;
  logic [31:0] rdData;

  typedef struct {
    logic [31:0] komut;
    logic [31:0] rdData;
    logic [6:0]  opcode;
    logic [3:0]  func;
    logic [31:0] imm;
    logic        we;
    logic        hata;
    logic        chkRs;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } vec_t;

  vec_t sbQ[$];
  vec_t tbl[17];

  int passCount = 0;
  int checkCount = 0;

  fetch_decode_unit dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .pc_update_i (pcUpdate),
    .pc_new_i    (pcNew),
    .pc_o        (pc),
    .komut_i     (komut),
    .opcode_o    (opcode),
    .func_o      (func),
    .rs1_data_o  (rs1Data),
    .rs2_data_o  (rs2Data),
    .imm_o       (imm),
    .hata_o      (hata),
    .we_o        (we),
    .rd_data_i   (rdData)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if the sequence stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  function automatic vec_t mkVec(input logic [31:0] k, input logic [31:0] d,
                                 input logic [6:0] op, input logic [3:0] fn,
                                 input logic [31:0] im, input logic w, input logic h,
                                 input logic c, input logic [31:0] r1, input logic [31:0] r2);
    vec_t v;
    v.komut = k; v.rdData = d; v.opcode = op; v.func = fn; v.imm = im;
    v.we = w; v.hata = h; v.chkRs = c; v.rs1 = r1; v.rs2 = r2;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    komut  = v.komut;
    rdData = v.rdData;
    sbQ.push_back(v);
  endtask

  task automatic checkOutput(input string tag);
    vec_t v;
    checkCount++;
    if (sbQ.size() == 0) begin
      $display("[TB] FAIL %s: scoreboard empty, got 0 entries expected 1", tag);
      return;
    end
    passCount++;
    v = sbQ.pop_front();
    checkVal({tag, ".opcode"}, {25'd0, opcode}, {25'd0, v.opcode});
    checkVal({tag, ".func"},   {28'd0, func},   {28'd0, v.func});
    checkVal({tag, ".imm"},    imm,             v.imm);
    checkVal({tag, ".we"},     {31'd0, we},     {31'd0, v.we});
    checkVal({tag, ".hata"},   {31'd0, hata},   {31'd0, v.hata});
    if (v.chkRs) begin
      checkVal({tag, ".rs1"}, rs1Data, v.rs1);
      checkVal({tag, ".rs2"}, rs2Data, v.rs2);
    end
  endtask

  task automatic runVec(input string tag, input vec_t v);
    @(negedge clk);
    applyStimulus(v);
    #2;
    checkOutput(tag);
  endtask

  // Main sequence: reset, PC stepping, decode table, register file corners
  initial begin
    tbl[0]  = mkVec(32'h00500093, 0, 7'h13, 4'h0, 32'h00000005, 1, 0, 0, 0, 0);
    tbl[1]  = mkVec(32'hFE000EE3, 0, 7'h63, 4'h8, 32'hFFFFFFFC, 0, 0, 0, 0, 0);
    tbl[2]  = mkVec(32'h12345037, 0, 7'h37, 4'h5, 32'h12345000, 1, 0, 0, 0, 0);
    tbl[3]  = mkVec(32'h0000007F, 0, 7'h7F, 4'h0, 32'h00000000, 0, 1, 0, 0, 0);
    tbl[4]  = mkVec(32'h40001033, 0, 7'h33, 4'h9, 32'h00000000, 0, 1, 0, 0, 0);
    tbl[5]  = mkVec(32'h40005033, 0, 7'h33, 4'hD, 32'h00000000, 1, 0, 0, 0, 0);
    tbl[6]  = mkVec(32'h4030D093, 0, 7'h13, 4'hD, 32'h00000403, 1, 0, 0, 0, 0);
    tbl[7]  = mkVec(32'h40309093, 0, 7'h13, 4'h9, 32'h00000403, 0, 1, 0, 0, 0);
    tbl[8]  = mkVec(32'h008000EF, 0, 7'h6F, 4'h0, 32'h00000008, 1, 0, 0, 0, 0);
    tbl[9]  = mkVec(32'hFE20AE23, 0, 7'h23, 4'hA, 32'hFFFFFFFC, 0, 0, 0, 0, 0);
    tbl[10] = mkVec(32'hFE20BE23, 0, 7'h23, 4'hB, 32'hFFFFFFFC, 0, 1, 0, 0, 0);
    tbl[11] = mkVec(32'h0000A183, 0, 7'h03, 4'h2, 32'h00000000, 1, 0, 0, 0, 0);
    tbl[12] = mkVec(32'h0000B183, 0, 7'h03, 4'h3, 32'h00000000, 0, 1, 0, 0, 0);
    tbl[13] = mkVec(32'h000090E7, 0, 7'h67, 4'h1, 32'h00000000, 0, 1, 0, 0, 0);
    tbl[14] = mkVec(32'h00002063, 0, 7'h63, 4'h2, 32'h00000000, 0, 1, 0, 0, 0);
    tbl[15] = mkVec(32'hFFFFF017, 0, 7'h17, 4'hF, 32'hFFFFF000, 1, 0, 0, 0, 0);
    tbl[16] = mkVec(32'h02000033, 0, 7'h33, 4'h0, 32'h00000000, 0, 1, 0, 0, 0);

    reset    = 1'b1;
    pcUpdate = 1'b0;
    pcNew    = 32'd0;
    komut    = 32'd0;
    rdData   = 32'd0;

    // Decode follows komut and PC holds its reset value while reset is high
    repeat (2) @(negedge clk);
    checkVal("pcInReset", pc, 32'h0);
    runVec("decodeInReset", mkVec(32'h00500093, 0, 7'h13, 4'h0, 32'h5, 1, 0, 1, 0, 0));

    // Release reset with an illegal word on komut so nothing is written
    @(negedge clk);
    komut = 32'd0;
    reset = 1'b0;
    #1;
    checkVal("pcAfterReset", pc, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      #1;
      checkVal($sformatf("pcStep%0d", i), pc, 32'(4 * i));
    end

    pcUpdate = 1'b1;
    pcNew    = 32'h00000043;
    @(negedge clk);
    #1;
    checkVal("pcJumpAligned", pc, 32'h40);
    pcUpdate = 1'b0;
    @(negedge clk);
    #1;
    checkVal("pcAfterJump", pc, 32'h44);
    pcUpdate = 1'b1;
    pcNew    = 32'hFFFFFFFC;
    @(negedge clk);
    #1;
    checkVal("pcTop", pc, 32'hFFFFFFFC);
    pcUpdate = 1'b0;
    @(negedge clk);
    #1;
    checkVal("pcWrap", pc, 32'h0);

    // Decode table; rd_data is zero so incidental writes leave registers at zero
    for (int i = 0; i < 17; i++) begin
      runVec($sformatf("tbl%0d", i), tbl[i]);
    end

    // Write-back and read ports, including the no-bypass case
    runVec("addiX1",   mkVec(32'h00500093, 32'd5,  7'h13, 4'h0, 32'h5, 1, 0, 1, 32'd0,  32'd0));
    runVec("addX2",    mkVec(32'h00108133, 32'd10, 7'h33, 4'h0, 32'h0, 1, 0, 1, 32'd5,  32'd5));
    runVec("noBypass", mkVec(32'h001080B3, 32'd99, 7'h33, 4'h0, 32'h0, 1, 0, 1, 32'd5,  32'd5));
    runVec("readX2",   mkVec(32'h002001B3, 32'h77, 7'h33, 4'h0, 32'h0, 1, 0, 1, 32'd0,  32'd10));
    runVec("readX1",   mkVec(32'h00008033, 32'd0,  7'h33, 4'h0, 32'h0, 1, 0, 1, 32'd99, 32'd0));

    // Writes to x0 are discarded
    runVec("writeX0",  mkVec(32'h00000013, 32'hDEAD, 7'h13, 4'h0, 32'h0, 1, 0, 1, 32'd0, 32'd0));
    runVec("readX0X3", mkVec(32'h00300033, 32'hDEAD, 7'h33, 4'h0, 32'h0, 1, 0, 1, 32'd0, 32'h77));

    // Reset in mid-cycle: PC and registers clear at once, pending write to x5 is lost
    @(negedge clk);
    komut  = 32'h02A00293;
    rdData = 32'd77;
    #1;
    reset = 1'b1;
    #1;
    checkVal("pcMidReset", pc, 32'h0);
    applyStimulus(mkVec(32'h00108033, 32'd0, 7'h33, 4'h0, 32'h0, 1, 0, 1, 32'd0, 32'd0));
    #1;
    checkOutput("regsMidReset");
    komut = 32'h02A00293;
    @(negedge clk);
    komut = 32'd0;
    reset = 1'b0;
    runVec("x5Aborted", mkVec(32'h00028033, 32'd0, 7'h33, 4'h0, 32'h0, 1, 0, 1, 32'd0, 32'd0));

    checkVal("sbDrained", 32'(sbQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
